// File: rtl/tog_dec_pkg.sv
// Shared types and constants for the toggle-event decoder.
// Build option: TOG_DEC_SYNC_EN adds an input synchronizer.
package tog_dec_pkg;

    typedef enum logic [1:0] {
        PRIME,
        ARM,
        RUN
    } dec_state_e;

    localparam int CNT_W_DEF        = 4;
    localparam int PRIME_LEN_NOSYNC = 1;
    localparam int PRIME_LEN_SYNC   = 3;

endpackage

// File: rtl/tog_event_decoder_if.sv
// Event queue handshake between the decoder and its consumer.
// Master side is the decoder; slave side is the consumer.
interface tog_event_decoder_if
    import tog_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] pend_cnt;

    modport master (
        output evt_valid,
        output pend_cnt,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  pend_cnt,
        output evt_ready
    );

endinterface

// File: rtl/tog_sync.sv
// Two-stage synchronizer for the toggle line.
// Used only when TOG_DEC_SYNC_EN is defined.
module tog_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/tog_event_decoder.sv
// Toggle-encoded event decoder with saturating pending counter.
// Build option: TOG_DEC_SYNC_EN inserts tog_sync ahead of tog_r.
module tog_event_decoder
    import tog_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_in,
    input  logic clr_ovf,
    output logic evt_pulse,
    output logic overflow,
    tog_event_decoder_if.master bus
);

    logic tog_s;

`ifdef TOG_DEC_SYNC_EN
    localparam int PRIME_LEN = PRIME_LEN_SYNC;

    tog_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (tog_s)
    );
`else
    localparam int PRIME_LEN = PRIME_LEN_NOSYNC;

    assign tog_s = tog_in;
`endif

    localparam logic [1:0] PRIME_LAST = 2'(PRIME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_state_e       state;
    dec_state_e       state_nx;
    logic [1:0]       prime_cnt;
    logic             tog_r;
    logic             tog_d;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic             sat;
    logic             set_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PRIME;
            prime_cnt <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == PRIME) begin
                prime_cnt <= prime_cnt + 2'd1;
            end else begin
                prime_cnt <= 2'd0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            PRIME: begin
                if (prime_cnt == PRIME_LAST) begin
                    state_nx = ARM;
                end
            end
            ARM:     state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_r <= 1'b0;
            tog_d <= 1'b0;
        end else begin
            tog_r <= tog_s;
            tog_d <= tog_r;
        end
    end

    // The start-up states let tog_d catch up with the level at release.
    assign evt_pulse = (state == RUN) & (tog_r ^ tog_d);

    assign pop     = bus.evt_valid & bus.evt_ready;
    assign sat     = (cnt == CNT_MAX);
    assign set_ovf = evt_pulse & ~pop & sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (evt_pulse && !pop && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !evt_pulse) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A lost event outranks a concurrent clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (set_ovf) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign bus.pend_cnt  = cnt;
    assign bus.evt_valid = |cnt;

endmodule
